ofs_fim_axi_mmio_csr_slave: RTL

AXI4-MMIO responder. Terminates the slave end of an ofs_fim_axi_mmio_if and converts each beat into a single-cycle access on a simple CSR register bus (write strobe, read request, read-data return). It sits between the MMIO fabric and the FME/port CSR banks. It handles one transaction at a time, with round-robin read/write arbitration and INCR/FIXED burst support.

---
 rtl/ofs_fim_axi_mmio_csr_pkg.sv | 24 ++
 rtl/ofs_fim_axi_mmio_csr_slave_if.sv | 59 +++++
 rtl/ofs_fim_axi_mmio_csr_arb.sv | 29 ++
 rtl/ofs_fim_axi_mmio_csr_slave.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ofs_fim_axi_mmio_csr_pkg.sv
// Shared definitions for the AXI4-MMIO to CSR-bus responder.
//   BEAT_BYTES     : byte stride of one 64-bit beat
//   RESP_*         : AXI response codes driven on bresp/rresp
//   BURST_*        : AXI burst type encodings
//   t_csr_slv_state: responder FSM states
//   burst_ok()     : 1 for burst types that get real CSR accesses
package ofs_fim_axi_mmio_csr_pkg;
  localparam int BEAT_BYTES = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_RESP, RD_REQ, RD_WAIT, RD_RESP
  } t_csr_slv_state;

  function automatic logic burst_ok(input logic [1:0] b);
    return (b == BURST_FIXED) || (b == BURST_INCR);
  endfunction
endpackage

// File: rtl/ofs_fim_axi_mmio_csr_slave_if.sv
// AXI4 MMIO bus bundle (ofs_fim_axi_mmio_if).
//   clk/rst_n : bus clock/reset carried with the bundle (the CSR responder
//               runs on its own clk/rst ports instead)
//   aw/w/b    : write address, data, response channels
//   ar/r      : read address, data channels
// Modports: master (initiator side), slave (responder side).
interface ofs_fim_axi_mmio_if #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 10
) (
  input logic clk,
  input logic rst_n
);
  logic                    awvalid, awready;
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;

  logic                    wvalid, wready, wlast;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;

  logic                    bvalid, bready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;

  logic                    arvalid, arready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;

  logic                    rvalid, rready, rlast;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    input  clk, rst_n,
    output awvalid, awid, awaddr, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bid, bresp, output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, input arready,
    input  rvalid, rid, rdata, rresp, rlast, output rready
  );

  // awsize/arsize are not part of the responder view: wstrb governs lanes.
  modport slave (
    input  awvalid, awid, awaddr, awlen, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bid, bresp, input bready,
    input  arvalid, arid, araddr, arlen, arburst, output arready,
    output rvalid, rid, rdata, rresp, rlast, input rready
  );
endinterface

// File: rtl/ofs_fim_axi_mmio_csr_arb.sv
// Two-way round-robin arbiter between a pending write and a pending read.
//   clk, rst        : clock, synchronous active-high reset
//   req_wr, req_rd  : awvalid / arvalid
//   take            : the responder is accepting a grant this cycle
//   gnt_wr, gnt_rd  : one-hot grant (combinational)
// The last-grant flop only moves when both requests competed, so a lone
// request never changes who wins the next contention. Reset = write,
// so the first contention goes to the read.
module ofs_fim_axi_mmio_csr_arb (
  input  logic clk,
  input  logic rst,
  input  logic req_wr,
  input  logic req_rd,
  input  logic take,
  output logic gnt_wr,
  output logic gnt_rd
);
  logic last_wr;

  always_comb begin
    gnt_wr = req_wr && (!req_rd || !last_wr);
    gnt_rd = req_rd && !gnt_wr;
  end

  always_ff @(posedge clk) begin
    if (rst)                           last_wr <= 1'b1;
    else if (take && req_wr && req_rd) last_wr <= gnt_wr;
  end
endmodule

// File: rtl/ofs_fim_axi_mmio_csr_slave.sv
// AXI4-MMIO responder: turns each AXI beat into a single-cycle access on a
// simple CSR bus. One transaction in flight, round-robin read/write
// arbitration, INCR/FIXED bursts (WRAP/reserved answered with SLVERR).
//   clk, rst   : clock, synchronous active-high reset
//   axi        : ofs_fim_axi_mmio_if.slave
//   csr_wr     : one-cycle write pulse with csr_addr/csr_wdata/csr_wstrb
//   csr_rd     : one-cycle read request with csr_addr
//   csr_rvalid : read-data return, csr_rdata valid
// Optional: OFS_FIM_AXI_MMIO_CSR_SLAVE_TIMEOUT_EN adds a read-completion
// timeout of TIMEOUT_CYCLES (all-ones data, SLVERR).
module ofs_fim_axi_mmio_csr_slave
  import ofs_fim_axi_mmio_csr_pkg::*;
#(
  parameter int ADDR_WIDTH     = 21,
  parameter int DATA_WIDTH     = 64,
  parameter int ID_WIDTH       = 10,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  ofs_fim_axi_mmio_if.slave       axi,
  output logic                    csr_wr,
  output logic                    csr_rd,
  output logic [ADDR_WIDTH-1:0]   csr_addr,
  output logic [DATA_WIDTH-1:0]   csr_wdata,
  output logic [DATA_WIDTH/8-1:0] csr_wstrb,
  input  logic                    csr_rvalid,
  input  logic [DATA_WIDTH-1:0]   csr_rdata
);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BEAT_BYTES-1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(BEAT_BYTES);

  t_csr_slv_state state, nstate;

  logic                  gnt_wr_q, gnt_rd_q, arb_wr, arb_rd, arb_take;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            beats_left;   // beats remaining after the current one
  logic                  incr_q, burst_err, resp_err, rd_err_q, timeout;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  aw_hs, ar_hs, w_hs, last_beat;

  assign aw_hs     = axi.awvalid && axi.awready;
  assign ar_hs     = axi.arvalid && axi.arready;
  assign w_hs      = axi.wvalid && axi.wready;
  assign last_beat = (beats_left == 8'd0);

  // Arbitrate once per idle period; the winner is registered and its
  // ready is raised for exactly one cycle on the following cycle.
  assign arb_take = (state == IDLE) && !gnt_wr_q && !gnt_rd_q;

  ofs_fim_axi_mmio_csr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_wr (axi.awvalid),
    .req_rd (axi.arvalid),
    .take   (arb_take),
    .gnt_wr (arb_wr),
    .gnt_rd (arb_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_wr_q <= 1'b0;
      gnt_rd_q <= 1'b0;
    end else if (arb_take) begin
      gnt_wr_q <= arb_wr;
      gnt_rd_q <= arb_rd;
    end else begin
      gnt_wr_q <= 1'b0;
      gnt_rd_q <= 1'b0;
    end
  end

`ifdef OFS_FIM_AXI_MMIO_CSR_SLAVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Counts cycles since the csr_rd pulse; fires so that the response
  // appears TIMEOUT_CYCLES after csr_rd.
  always_ff @(posedge clk) begin
    if (rst)                     to_cnt <= '0;
    else if (state == RD_REQ)    to_cnt <= TW'(1);
    else if (state == RD_WAIT)   to_cnt <= to_cnt + TW'(1);
  end

  assign timeout = (state == RD_WAIT) && !csr_rvalid &&
                   (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next state
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (aw_hs) nstate = WR_DATA;
               else if (ar_hs) nstate = RD_REQ;
      WR_DATA: if (w_hs && last_beat) nstate = WR_RESP;
      WR_RESP: if (axi.bready) nstate = IDLE;
      RD_REQ:  nstate = burst_err ? RD_RESP : RD_WAIT;
      RD_WAIT: if (csr_rvalid || timeout) nstate = RD_RESP;
      RD_RESP: if (axi.rready) nstate = last_beat ? IDLE : RD_REQ;
      default: nstate = IDLE;
    endcase
  end

  // Outputs decoded from state and the transaction registers
  always_comb begin
    axi.awready = (state == IDLE) && gnt_wr_q;
    axi.arready = (state == IDLE) && gnt_rd_q;
    axi.wready  = (state == WR_DATA);
    axi.bvalid  = (state == WR_RESP);
    axi.bid     = id_q;
    axi.bresp   = resp_err ? RESP_SLVERR : RESP_OKAY;
    axi.rvalid  = (state == RD_RESP);
    axi.rid     = id_q;
    axi.rdata   = rdata_q;
    axi.rresp   = rd_err_q ? RESP_SLVERR : RESP_OKAY;
    axi.rlast   = (state == RD_RESP) && last_beat;
    csr_rd      = (state == RD_REQ) && !burst_err;
    csr_addr    = addr_q;
  end

  // Transaction datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q       <= '0;
      addr_q     <= '0;
      beats_left <= '0;
      incr_q     <= 1'b0;
      burst_err  <= 1'b0;
      resp_err   <= 1'b0;
      rd_err_q   <= 1'b0;
      rdata_q    <= '0;
      csr_wr     <= 1'b0;
      csr_wdata  <= '0;
      csr_wstrb  <= '0;
    end else begin
      csr_wr <= w_hs && !burst_err;

      if (aw_hs) begin
        id_q       <= axi.awid;
        addr_q     <= axi.awaddr & ALIGN_MASK;
        beats_left <= axi.awlen;
        incr_q     <= (axi.awburst == BURST_INCR);
        burst_err  <= !burst_ok(axi.awburst);
        resp_err   <= !burst_ok(axi.awburst);
      end else if (ar_hs) begin
        id_q       <= axi.arid;
        addr_q     <= axi.araddr & ALIGN_MASK;
        beats_left <= axi.arlen;
        incr_q     <= (axi.arburst == BURST_INCR);
        burst_err  <= !burst_ok(axi.arburst);
      end

      if (w_hs) begin
        csr_wdata  <= axi.wdata;
        csr_wstrb  <= axi.wstrb;
        beats_left <= beats_left - 8'd1;
        // A misplaced wlast only flags the error; len still ends the burst.
        if (axi.wlast != last_beat) resp_err <= 1'b1;
      end

      // Write address advances after the beat's csr_wr has gone out.
      if (csr_wr && incr_q) addr_q <= addr_q + STRIDE;

      if (state == RD_REQ && burst_err) begin
        rdata_q  <= '0;
        rd_err_q <= 1'b1;
      end else if (state == RD_WAIT && csr_rvalid) begin
        rdata_q  <= csr_rdata;
        rd_err_q <= 1'b0;
      end else if (timeout) begin
        rdata_q  <= '1;
        rd_err_q <= 1'b1;
      end

      if (state == RD_RESP && axi.rready && !last_beat) begin
        beats_left <= beats_left - 8'd1;
        if (incr_q) addr_q <= addr_q + STRIDE;
      end
    end
  end
endmodule
